// File: rtl/pe_stream_driver_if.sv
// Operand, PE-port and result stream bundle for pe_stream_driver.
// slave is the driver side, master is the fetch/PE/writeback side.
interface pe_stream_driver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  op_valid;
  logic                  op_ready;
  logic [1:0]            op_mode;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  op_last;
  logic                  pe_valid_in;
  logic [1:0]            pe_mode;
  logic [DATA_WIDTH-1:0] pe_a;
  logic [DATA_WIDTH-1:0] pe_b;
  logic [ACC_WIDTH-1:0]  pe_acc;
  logic [ACC_WIDTH-1:0]  pe_result;
  logic                  pe_valid_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic [1:0]            res_mode;
  logic [LEN_WIDTH-1:0]  res_len;
  logic                  err;

  modport slave (
    input  op_valid, op_mode, op_a, op_b, op_last,
    input  pe_result, pe_valid_out, res_ready,
    output op_ready, pe_valid_in, pe_mode, pe_a, pe_b, pe_acc,
    output res_valid, res_data, res_mode, res_len, err
  );

  modport master (
    output op_valid, op_mode, op_a, op_b, op_last,
    output pe_result, pe_valid_out, res_ready,
    input  op_ready, pe_valid_in, pe_mode, pe_a, pe_b, pe_acc,
    input  res_valid, res_data, res_mode, res_len, err
  );
endinterface

// File: rtl/pe_stream_driver.sv
// Operand-stream sequencer for the PE: MAC chaining via result feedback,
// credit-protected result FIFO and ready/valid result stream.
module pe_stream_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input logic clk,
  input logic rst_n,
  pe_stream_driver_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  localparam logic [1:0] M_MAC = 2'b00;
  localparam logic [1:0] M_EWM = 2'b01;
  localparam logic [1:0] M_EWA = 2'b10;
  localparam logic [1:0] M_BAD = 2'b11;

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [1:0]           mode;
    logic [LEN_WIDTH-1:0] len;
  } entry_t;

  state_t               state, state_nx;
  logic                 accept, is_mac, is_ew, is_bad;
  logic                 produce, abort, issue, err_c;
  logic                 chain_now;
  logic [LEN_WIDTH-1:0] len_cnt, len_nx, beat_len;
  logic [ACC_WIDTH-1:0] acc_hold;
  logic                 infl_prod, infl_chain;
  logic [1:0]           infl_mode;
  logic [LEN_WIDTH-1:0] infl_len;
  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 fifo_wr, fifo_rd, res_valid;
  logic [CW:0]          credit;

  assign is_mac = bus.op_mode == M_MAC;
  assign is_ew  = bus.op_mode == M_EWM
               || bus.op_mode == M_EWA;
  assign is_bad = bus.op_mode == M_BAD;

  assign res_valid = count != '0;
  assign fifo_rd   = res_valid && bus.res_ready;
  assign fifo_wr   = bus.pe_valid_out && infl_prod;
  assign chain_now = bus.pe_valid_out && infl_chain;

  // A read in this cycle returns its slot to the issue side at once
  assign credit = {1'b0, count}
                + {{CW{1'b0}}, infl_prod}
                - {{CW{1'b0}}, fifo_rd};

  assign bus.op_ready = rst_n && (credit < DEPTH_C);
  assign accept = bus.op_valid && bus.op_ready;

  assign beat_len = (state == IDLE) ? LEN_WIDTH'(1)
                  : (&len_cnt) ? len_cnt
                  : len_cnt + LEN_WIDTH'(1);

  always_comb begin
    state_nx = state;
    len_nx   = len_cnt;
    produce  = 1'b0;
    abort    = 1'b0;
    issue    = 1'b0;
    err_c    = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_bad: begin
          err_c    = 1'b1;
          abort    = state == ACCUM;
          state_nx = IDLE;
          len_nx   = '0;
        end
        is_ew: begin
          issue    = 1'b1;
          produce  = 1'b1;
          err_c    = state == ACCUM;
          abort    = state == ACCUM;
          state_nx = IDLE;
          len_nx   = '0;
        end
        is_mac: begin
          issue    = 1'b1;
          produce  = bus.op_last;
          state_nx = bus.op_last ? IDLE : ACCUM;
          len_nx   = bus.op_last ? '0 : beat_len;
        end
        default: ;
      endcase
    end
  end

  assign bus.pe_valid_in = issue;
  assign bus.pe_mode     = bus.op_mode;
  assign bus.pe_a        = bus.op_a;
  assign bus.pe_b        = bus.op_b;
  assign bus.pe_acc      = (state == IDLE) ? '0
                         : chain_now ? bus.pe_result
                         : acc_hold;
  assign bus.err         = err_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_cnt    <= '0;
      acc_hold   <= '0;
      infl_prod  <= 1'b0;
      infl_chain <= 1'b0;
      infl_mode  <= '0;
      infl_len   <= '0;
    end else begin
      state      <= state_nx;
      len_cnt    <= len_nx;
      infl_prod  <= produce;
      infl_chain <= issue && is_mac && !bus.op_last;
      infl_mode  <= bus.op_mode;
      infl_len   <= is_mac ? beat_len : LEN_WIDTH'(1);
      if (abort)
        acc_hold <= '0;
      else if (chain_now)
        acc_hold <= bus.pe_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (fifo_wr) begin
        mem[wr_ptr] <= '{bus.pe_result, infl_mode, infl_len};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (fifo_rd)
        rd_ptr <= rd_ptr + PW'(1);
      if (fifo_wr && !fifo_rd)
        count <= count + CW'(1);
      else if (!fifo_wr && fifo_rd)
        count <= count - CW'(1);
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.res_valid = res_valid;
  assign bus.res_data  = head.data;
  assign bus.res_mode  = head.mode;
  assign bus.res_len   = head.len;
endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed bench for pe_stream_driver with a 1-cycle Q8.8/Q16.16 PE model.
// Inputs change 1 time unit after the rising edge; outputs sampled mid-cycle.
module tb_pe_stream_driver;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  pe_stream_driver_if #(
    .DATA_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8)
  ) bus ();

  pe_stream_driver #(
    .DATA_WIDTH(16), .ACC_WIDTH(32),
    .FIFO_DEPTH(4), .LEN_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pe_f(
    input logic [1:0] m, input logic [15:0] a,
    input logic [15:0] b, input logic [31:0] acc
  );
    logic [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    case (m)
      2'b00:   return acc + sa * sb;
      2'b01:   return sa * sb;
      2'b10:   return (sa + sb) << 8;
      default: return 32'h0;
    endcase
  endfunction

  // The PE itself: registered result, one cycle after issue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pe_valid_out <= 1'b0;
      bus.pe_result    <= 32'h0;
    end else begin
      bus.pe_valid_out <= bus.pe_valid_in;
      bus.pe_result    <= pe_f(bus.pe_mode, bus.pe_a,
                               bus.pe_b, bus.pe_acc);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag,
                        input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [15:0] a,
                       input logic [15:0] b, input logic last);
    bus.op_valid = 1'b1;
    bus.op_mode  = m;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_last  = last;
  endtask

  task automatic idle();
    bus.op_valid = 1'b0;
    bus.op_last  = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] d,
                            input logic [1:0] m, input logic [7:0] l);
    check1({tag, "_valid"}, bus.res_valid, 1'b1);
    check({tag, "_data"}, bus.res_data, d);
    check({tag, "_mode"}, 32'(bus.res_mode), 32'(m));
    check({tag, "_len"}, 32'(bus.res_len), 32'(l));
  endtask

  task automatic pop();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
  endtask

  task automatic reset_vals(input string tag);
    check1({tag, "_op_ready"}, bus.op_ready, 1'b0);
    check1({tag, "_pe_valid_in"}, bus.pe_valid_in, 1'b0);
    check1({tag, "_res_valid"}, bus.res_valid, 1'b0);
    check({tag, "_res_data"}, bus.res_data, 32'h0);
    check({tag, "_res_mode"}, 32'(bus.res_mode), 32'h0);
    check({tag, "_res_len"}, 32'(bus.res_len), 32'h0);
    check1({tag, "_err"}, bus.err, 1'b0);
    check({tag, "_pe_acc"}, bus.pe_acc, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_mode   = 2'b00;
    bus.op_a      = 16'h0;
    bus.op_b      = 16'h0;
    bus.op_last   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    rst_n = 1'b1;
    #1;
    check1("rst_release_op_ready", bus.op_ready, 1'b1);
    tick();

    // EWM
    drive(2'b01, 16'h0100, 16'h0200, 1'b0);
    #1;
    check1("ewm_issue", bus.pe_valid_in, 1'b1);
    check1("ewm_err", bus.err, 1'b0);
    tick();
    idle();
    #1;
    check1("ewm_t1_res_valid", bus.res_valid, 1'b0);
    tick();
    expect_res("ewm", 32'h0002_0000, 2'b01, 8'd1);
    pop();
    check1("ewm_drained", bus.res_valid, 1'b0);

    // EWA
    drive(2'b10, 16'h0180, 16'h0240, 1'b0);
    tick();
    idle();
    tick();
    expect_res("ewa", 32'h0003_C000, 2'b10, 8'd1);
    pop();

    // MAC group with a 2-cycle gap before the last beat
    drive(2'b00, 16'h0100, 16'h0200, 1'b0);
    #1;
    check("mac_b1_acc", bus.pe_acc, 32'h0);
    check1("mac_b1_issue", bus.pe_valid_in, 1'b1);
    tick();
    drive(2'b00, 16'h0300, 16'h0100, 1'b0);
    #1;
    check("mac_b2_acc", bus.pe_acc, 32'h0002_0000);
    tick();
    idle();
    #1;
    check1("mac_gap1_res", bus.res_valid, 1'b0);
    tick();
    check1("mac_gap2_res", bus.res_valid, 1'b0);
    tick();
    drive(2'b00, 16'hFF00, 16'h0100, 1'b1);
    #1;
    check("mac_b3_acc", bus.pe_acc, 32'h0005_0000);
    tick();
    idle();
    tick();
    expect_res("mac", 32'h0004_0000, 2'b00, 8'd3);
    pop();
    check1("mac_single_result", bus.res_valid, 1'b0);

    // Backpressure: four results fill the FIFO
    for (int k = 1; k <= 4; k++) begin
      drive(2'b01, 16'h0100, 16'(k * 256), 1'b0);
      #1;
      check1($sformatf("bp_ready_%0d", k), bus.op_ready, 1'b1);
      tick();
    end
    drive(2'b01, 16'h0100, 16'h0500, 1'b0);
    #1;
    check1("bp_full_ready", bus.op_ready, 1'b0);
    check1("bp_full_issue", bus.pe_valid_in, 1'b0);
    tick();
    check1("bp_full_ready2", bus.op_ready, 1'b0);
    bus.res_ready = 1'b1;
    #1;
    check1("bp_read_reopens", bus.op_ready, 1'b1);
    check1("bp_read_issue", bus.pe_valid_in, 1'b1);
    check("bp_head", bus.res_data, 32'h0001_0000);
    tick();
    bus.res_ready = 1'b0;
    idle();
    for (int k = 2; k <= 5; k++) begin
      #1;
      check1($sformatf("bp_drain_v%0d", k), bus.res_valid, 1'b1);
      check($sformatf("bp_drain_d%0d", k), bus.res_data,
            32'(k) << 16);
      pop();
    end
    check1("bp_empty", bus.res_valid, 1'b0);

    // Open MAC group aborted by an EWA beat
    drive(2'b00, 16'h0100, 16'h0100, 1'b0);
    tick();
    drive(2'b00, 16'h0100, 16'h0100, 1'b0);
    tick();
    drive(2'b10, 16'h0100, 16'h0100, 1'b0);
    #1;
    check1("abort_err", bus.err, 1'b1);
    check1("abort_issue", bus.pe_valid_in, 1'b1);
    tick();
    idle();
    #1;
    check1("abort_err_pulse", bus.err, 1'b0);
    tick();
    expect_res("abort_ewa", 32'h0002_0000, 2'b10, 8'd1);
    pop();
    check1("abort_no_mac", bus.res_valid, 1'b0);
    drive(2'b00, 16'h0200, 16'h0100, 1'b1);
    #1;
    check("abort_fresh_acc", bus.pe_acc, 32'h0);
    tick();
    idle();
    tick();
    expect_res("abort_fresh", 32'h0002_0000, 2'b00, 8'd1);
    pop();

    // Illegal mode
    drive(2'b11, 16'h1234, 16'h5678, 1'b0);
    #1;
    check1("bad_ready", bus.op_ready, 1'b1);
    check1("bad_err", bus.err, 1'b1);
    check1("bad_no_issue", bus.pe_valid_in, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check1("bad_no_result", bus.res_valid, 1'b0);

    // Reset in the middle of an open group
    drive(2'b00, 16'h0100, 16'h0200, 1'b0);
    tick();
    drive(2'b00, 16'h0100, 16'h0200, 1'b0);
    tick();
    drive(2'b00, 16'h0100, 16'h0200, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    drive(2'b00, 16'h0100, 16'h0100, 1'b1);
    #1;
    check("post_rst_acc", bus.pe_acc, 32'h0);
    tick();
    idle();
    tick();
    expect_res("post_rst", 32'h0001_0000, 2'b00, 8'd1);
    pop();
    check1("post_rst_empty", bus.res_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
